// File: rtl/rom_sum_pkg.sv
// Shared types and constants for the ROM summing sequencer and its port arbiter.
package rom_sum_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int SUM_W_DEF  = 32;

  // Length of the built-in puzzle and the sum its first PUZZLE_COUNT words produce.
  localparam int PUZZLE_COUNT = 200;
  localparam int EXPECTED_SUM = 17092;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rom_port_arbiter.sv
// Shares the single ROM read port between the sequencer and the host read port.
// The host wins unless it was granted last cycle while the sequencer is running.
module rom_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_req_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic              seq_active_i,
  input  logic [ADDR_W-1:0] seq_addr_i,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              host_grant_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              host_ack_o,
  output logic [DATA_W-1:0] host_data_o,
  output logic              gnt_last_o
);

  logic              gnt_last_q;
  logic              host_ack_q;
  logic [DATA_W-1:0] host_data_q;

  // Alternation: a running sequencer always gets the cycle after a host grant.
  assign host_grant_o = host_req_i && !(seq_active_i && gnt_last_q);
  assign rom_addr_o   = host_grant_o ? host_addr_i : seq_addr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_last_q  <= 1'b0;
      host_ack_q  <= 1'b0;
      host_data_q <= '0;
    end else begin
      gnt_last_q <= host_grant_o;
      host_ack_q <= host_grant_o;
      if (host_grant_o) begin
        host_data_q <= rom_data_i;
      end
    end
  end

  assign host_ack_o  = host_ack_q;
  assign host_data_o = host_data_q;
  assign gnt_last_o  = gnt_last_q;

endmodule

// File: rtl/rom_sum_sequencer.sv
// Walks ROM addresses 0..count-1, accumulating the words into a wrapping sum with
// a sticky carry-out flag, and pulses done for one cycle when the run completes.
module rom_sum_sequencer
  import rom_sum_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum,
  output logic              overflow,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_data,
  output logic [1:0]        dbg_state
);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              ovf_q, ovf_d;

  logic              host_grant;
  logic              gnt_last;
  logic              seq_active;
  logic              seq_step;
  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W:0]   idx_nxt;
  logic [SUM_W:0]    add_w;

  assign seq_active = (state_q == RUN);
  assign seq_addr   = seq_active ? idx_q[ADDR_W-1:0] : '0;
  assign seq_step   = seq_active && !host_grant;
  assign idx_nxt    = idx_q + (ADDR_W+1)'(1);
  // One extra bit on the adder captures the carry-out for the overflow flag.
  assign add_w      = {1'b0, sum_q} + {{(SUM_W+1-DATA_W){1'b0}}, rom_data};

  rom_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_req_i   (host_req),
    .host_addr_i  (host_addr),
    .seq_active_i (seq_active),
    .seq_addr_i   (seq_addr),
    .rom_data_i   (rom_data),
    .host_grant_o (host_grant),
    .rom_addr_o   (rom_addr),
    .host_ack_o   (host_ack),
    .host_data_o  (host_data),
    .gnt_last_o   (gnt_last)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sum_d   = '0;
          ovf_d   = 1'b0;
          count_d = count;
          idx_d   = '0;
          state_d = (count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (seq_step) begin
          sum_d = add_w[SUM_W-1:0];
          if (add_w[SUM_W]) begin
            ovf_d = 1'b1;
          end
          idx_d = idx_nxt;
          if (idx_nxt == count_q) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      count_q <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rom_sum_sequencer.sv
// Directed bench for rom_sum_sequencer: table of runs with hand-computed sums plus
// hand-written sequences for host alternation, DONE-time starts and mid-run reset.
module tb_rom_sum_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  count = '0;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        overflow;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        host_req = 1'b0;
  logic [7:0]  host_addr = '0;
  logic        host_ack;
  logic [31:0] host_data;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int rom_mode = 0;
  logic [31:0] exp_q[$];

  rom_sum_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .overflow  (overflow),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .host_req  (host_req),
    .host_addr (host_addr),
    .host_ack  (host_ack),
    .host_data (host_data),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ROM models: 0 = puzzle (177, then 85 x199, sums to 17092), 1 = all ones, 2 = identity.
  always_comb begin
    case (rom_mode)
      0:       rom_data = (rom_addr == 8'd0) ? 32'd177 :
                          ((rom_addr < 8'd200) ? 32'd85 : {24'd0, rom_addr});
      1:       rom_data = 32'hFFFF_FFFF;
      default: rom_data = {24'd0, rom_addr};
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start(input int c);
    start = 1'b1;
    count = c[8:0];
    step();
    start = 1'b0;
  endtask

  // Waits for done from the sample right after the accepting edge; returns edges taken.
  task automatic run_wait(input int limit, output int n, output int busy_n,
                          output int ack_n, output int b2b, output logic [7:0] last_addr);
    logic prev_ack;
    n = 0; busy_n = 0; ack_n = 0; b2b = 0; last_addr = '0; prev_ack = 1'b0;
    while (!done && n < limit) begin
      if (busy) busy_n++;
      if (busy && !host_req) last_addr = rom_addr;
      if (n > 0 && host_ack) begin
        ack_n++;
        chk("host_data", host_data, 32'd85);
        if (prev_ack) b2b++;
      end
      prev_ack = host_ack;
      step();
      n++;
    end
  endtask

  typedef struct {
    int          mode;
    int          cnt;
    logic [31:0] exp_sum;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, busy_n, ack_n, b2b;
    logic [7:0] last_addr;
    logic [31:0] exp_sum;

    vecs[0] = '{0, 200, 32'd17092,      1'b0};
    vecs[1] = '{0, 1,   32'd177,        1'b0};
    vecs[2] = '{0, 0,   32'd0,          1'b0};
    vecs[3] = '{1, 2,   32'hFFFF_FFFE,  1'b1};
    vecs[4] = '{2, 256, 32'd32640,      1'b0};
    vecs[5] = '{2, 10,  32'd45,         1'b0};
    vecs[6] = '{0, 3,   32'd347,        1'b0};

    // ---------------- reset ----------------
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ack", host_ack, 0);
    chk("rst_hdata", host_data, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_addr", rom_addr, 0);
    rst_n = 1'b1;
    step();

    // ---------------- table-driven runs, no host traffic ----------------
    for (int i = 0; i < 7; i++) begin
      rom_mode = vecs[i].mode;
      exp_q.push_back(vecs[i].exp_sum);
      do_start(vecs[i].cnt);
      run_wait(2000, n, busy_n, ack_n, b2b, last_addr);
      chk("v_latency", n, vecs[i].cnt);
      chk("v_busy_cycles", busy_n, vecs[i].cnt);
      chk("v_done", done, 1);
      chk("v_busy_in_done", busy, 0);
      exp_sum = exp_q.pop_front();
      chk("v_sum", sum, exp_sum);
      chk("v_ovf", overflow, vecs[i].exp_ovf);
      if (vecs[i].cnt != 0) chk("v_last_addr", last_addr, vecs[i].cnt - 1);
      step();
      chk("v_done_pulse", done, 0);
      chk("v_idle", dbg_state, 0);
      chk("v_sum_held", sum, exp_sum);
    end

    // ---------------- overflow then cleared by new start ----------------
    rom_mode = 1;
    do_start(2);
    run_wait(50, n, busy_n, ack_n, b2b, last_addr);
    chk("ovf_sum", sum, 32'hFFFF_FFFE);
    chk("ovf_flag", overflow, 1);
    repeat (3) step();
    chk("ovf_sticky", overflow, 1);
    rom_mode = 0;
    do_start(1);
    chk("ovf_clr_sum", sum, 0);
    chk("ovf_clr_flag", overflow, 0);
    run_wait(50, n, busy_n, ack_n, b2b, last_addr);
    chk("ovf_new_sum", sum, 32'd177);
    step();

    // ---------------- start during DONE ignored ----------------
    do_start(0);
    chk("z_done_now", done, 1);
    start = 1'b1;
    count = 9'd5;
    step();
    start = 1'b0;
    chk("z_ign_state", dbg_state, 0);
    chk("z_ign_busy", busy, 0);
    step();
    chk("z_ign_still_idle", dbg_state, 0);
    chk("z_ign_sum", sum, 0);

    // ---------------- start in IDLE right after DONE accepted ----------------
    do_start(0);
    chk("z2_done_now", done, 1);
    start = 1'b1;
    count = 9'd3;
    step();
    chk("z2_ign_in_done", dbg_state, 0);
    step();
    start = 1'b0;
    chk("z2_accepted", busy, 1);
    run_wait(50, n, busy_n, ack_n, b2b, last_addr);
    chk("z2_latency", n, 3);
    chk("z2_sum", sum, 32'd347);
    step();

    // ---------------- host held high throughout ----------------
    host_addr = 8'd5;
    host_req  = 1'b1;
    step();
    chk("h_idle_ack", host_ack, 1);
    chk("h_idle_data", host_data, 32'd85);
    do_start(200);
    run_wait(2000, n, busy_n, ack_n, b2b, last_addr);
    chk("h_latency", n, 399);
    chk("h_acks", ack_n, 199);
    chk("h_back_to_back", b2b, 0);
    chk("h_sum", sum, 32'd17092);
    chk("h_ovf", overflow, 0);
    host_req = 1'b0;
    step();

    // ---------------- reset mid-run ----------------
    do_start(200);
    repeat (100) step();
    chk("r_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_sum", sum, 0);
    chk("r_ovf", overflow, 0);
    chk("r_ack", host_ack, 0);
    chk("r_hdata", host_data, 0);
    chk("r_state", dbg_state, 0);
    step();
    step();
    rst_n = 1'b1;
    begin
      int dones;
      dones = 0;
      for (int k = 0; k < 10; k++) begin
        step();
        if (done) dones++;
      end
      chk("r_no_done", dones, 0);
    end
    do_start(200);
    run_wait(2000, n, busy_n, ack_n, b2b, last_addr);
    chk("r_rerun_latency", n, 200);
    chk("r_rerun_sum", sum, 32'd17092);
    step();

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
